rr_lock_arbiter: RTL and testbench

//   Parametrised N-way round-robin arbiter with grant locking, used per output port of the

---
 rtl/rr_lock_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_rr_lock_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter
//   N-way round-robin arbiter with packet locking. A granted requester keeps the
//   port while its request stays high. On release, the grant moves straight to the
//   next pending requester in round-robin order, with no idle cycle in between.
//   All outputs are registered, so there is no combinational req->gnt path.
//
//   Optional feature macro: ARB_HOLD_LIMIT_EN
//     When defined, a lock that has lasted HOLD_MAX cycles is force-released if
//     another requester is waiting. The counter saturates when nobody else is waiting.
//     When undefined, a lock is held for as long as the owner keeps requesting.
module rr_lock_arbiter #(
  parameter int unsigned NUM_REQ  = 5,
  parameter int unsigned ID_W     = 3,
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id
);

  // Reject bad parameter sets at elaboration time.
  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("rr_lock_arbiter: NUM_REQ must be at least 2");
  end
  if (ID_W < $clog2(NUM_REQ)) begin : g_bad_id_w
    $error("rr_lock_arbiter: ID_W too narrow for NUM_REQ");
  end
  if (HOLD_MAX < 1) begin : g_bad_hold_max
    $error("rr_lock_arbiter: HOLD_MAX must be at least 1");
  end

  // Index of the highest requester. The pointer wraps on an explicit compare
  // against it, because NUM_REQ need not be a power of two.
  localparam logic [ID_W-1:0] LastIdx = ID_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    StIdle,
    StLock
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               valid_q, valid_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;

  logic [NUM_REQ-1:0] own_req;
  logic [NUM_REQ-1:0] other_req;
  logic [ID_W-1:0]    ptr_after_owner;
  logic               hold_expired;
  logic               lock_release;

  // First set bit of r at or above start; if none there, the lowest set bit.
  // Callers guarantee r is non-zero.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [ID_W-1:0]    start);
    logic [ID_W-1:0] pick;
    logic            found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!found && r[j] && (ID_W'(j) >= start)) begin
        found = 1'b1;
        pick  = ID_W'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!found && r[j]) begin
        found = 1'b1;
        pick  = ID_W'(j);
      end
    end
    return pick;
  endfunction

  // Binary index to one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [ID_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (ID_W'(j) == idx) begin
        oh[j] = 1'b1;
      end
    end
    return oh;
  endfunction

  // Split the request vector into the current owner's bit and everybody else.
  // Masking the owner out of other_req is what stops a released requester from
  // being re-selected in the same cycle it lets go.
  assign own_req         = req & gnt_q;
  assign other_req       = req & ~gnt_q;
  assign ptr_after_owner = (id_q == LastIdx) ? '0 : id_q + ID_W'(1);

`ifdef ARB_HOLD_LIMIT_EN
  localparam int unsigned    HoldW    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_MAX - 1);

  logic [HoldW-1:0] hold_q, hold_d;

  assign hold_expired = (hold_q == HoldLast);

  // Hold counter: counts locked cycles, saturates, clears whenever the lock ends.
  always_comb begin
    hold_d = '0;
    if ((state_q == StLock) && !lock_release) begin
      hold_d = hold_expired ? hold_q : hold_q + HoldW'(1);
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  // Lock ends when the owner drops its request, or when its hold budget is
  // spent and somebody else is waiting.
  assign lock_release = (state_q == StLock) &&
                        (!(|own_req) || (hold_expired && (|other_req)));

  // Next-state and next-grant logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          id_d    = rr_pick(req, ptr_q);
          gnt_d   = to_onehot(id_d);
          valid_d = 1'b1;
          state_d = StLock;
        end
      end
      StLock: begin
        if (lock_release) begin
          ptr_d = ptr_after_owner;
          if (|other_req) begin
            // Direct hand-over: no idle cycle between owners.
            id_d  = rr_pick(other_req, ptr_after_owner);
            gnt_d = to_onehot(id_d);
          end else begin
            // gnt_id keeps its last value while idle.
            gnt_d   = '0;
            valid_d = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        valid_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_id    = id_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Testbench for rr_lock_arbiter: directed scenarios plus random traffic, checked
// by a scoreboard fed from a round-robin reference model.
module tb_rr_lock_arbiter;

  localparam int NR = 5;
  localparam int IW = 3;
  localparam int HM = 4;
`ifdef ARB_HOLD_LIMIT_EN
  localparam bit LimitEn = 1'b1;
`else
  localparam bit LimitEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req;
  logic [NR-1:0] gnt;
  logic          gnt_valid;
  logic [IW-1:0] gnt_id;

  rr_lock_arbiter #(
    .NUM_REQ (NR),
    .ID_W    (IW),
    .HOLD_MAX(HM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NR-1:0] g;
    logic          v;
    logic [IW-1:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state: owner index (-1 when idle), rr pointer, locked cycles.
  int m_owner;
  int m_ptr;
  int m_held;
  int m_last_id;

  function automatic bit bit_set(input logic [NR-1:0] r, input int idx);
    return ((r >> idx) & NR'(1)) != 0;
  endfunction

  function automatic int first_from(input logic [NR-1:0] r, input int start);
    for (int i = 0; i < NR; i++) begin
      if (bit_set(r, (start + i) % NR)) return (start + i) % NR;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner   = -1;
    m_ptr     = 0;
    m_held    = 0;
    m_last_id = 0;
  endtask

  task automatic model_step(input logic [NR-1:0] r);
    logic [NR-1:0] others;
    bit            force_rel;
    if (m_owner < 0) begin
      if (r != 0) begin
        m_owner = first_from(r, m_ptr);
        m_held  = 0;
      end
    end else begin
      others    = r & ~(NR'(1) << m_owner);
      force_rel = LimitEn && (m_held == HM - 1) && (others != 0);
      if (!bit_set(r, m_owner) || force_rel) begin
        m_ptr   = (m_owner + 1) % NR;
        m_owner = first_from(others, m_ptr);
        m_held  = 0;
      end else if (m_held < HM - 1) begin
        m_held++;
      end
    end
    if (m_owner >= 0) m_last_id = m_owner;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.g  = (m_owner >= 0) ? (NR'(1) << m_owner) : '0;
    e.v  = (m_owner >= 0);
    e.id = IW'(m_last_id);
    return e;
  endfunction

  // Drive one request vector for one cycle and queue the expected response.
  task automatic step(input logic [NR-1:0] r);
    @(negedge clk);
    req = r;
    model_step(r);
    exp_q.push_back(model_out());
  endtask

  task automatic check_now(input string name, input exp_t want);
    vectors++;
    if ({gnt, gnt_valid, gnt_id} !== want) begin
      miscompares++;
      $display("FAIL %s: got gnt=%b valid=%b id=%0d, want gnt=%b valid=%b id=%0d",
               name, gnt, gnt_valid, gnt_id, want.g, want.v, want.id);
    end
  endtask

  // Monitor: the DUT presents a registered grant every cycle; compare just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ({gnt, gnt_valid, gnt_id} !== e) begin
          miscompares++;
          $display("FAIL grant @%0t: got gnt=%b valid=%b id=%0d, want gnt=%b valid=%b id=%0d",
                   $time, gnt, gnt_valid, gnt_id, e.g, e.v, e.id);
        end
      end
    end
  end

  initial begin
    logic [NR-1:0] r;
    exp_t          zero_out;
    int            budget;
    zero_out = '0;
    rst = 1'b1;
    req = '0;
    model_reset();
    #12;
    check_now("reset", zero_out);
    @(negedge clk);
    rst = 1'b0;

    // Grant from idle, hold while requested, hand over with no gap.
    step(5'b00110);
    repeat (10) step(5'b00110);
    step(5'b00100);
    step(5'b00100);

    // Lock on 4, then wrap to 0, then go idle with gnt_id held.
    step(5'b10000);
    step(5'b10000);
    step(5'b00001);
    step(5'b00000);
    step(5'b00000);

    // Asynchronous reset in the middle of a lock on 3.
    step(5'b01000);
    step(5'b01000);
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_now("async_reset", zero_out);
    @(posedge clk);
    #3;
    check_now("reset_held", zero_out);
    rst = 1'b0;
    step(5'b01001);
    step(5'b01001);

    // Everyone requesting; each owner drops for one cycle after one grant cycle.
    step(5'b11111);
    repeat (6) step(5'b11111 & ~(NR'(1) << m_owner));
    step(5'b00000);

    // Two constant requesters: alternation with the hold limit, else a fixed lock.
    repeat (12) step(5'b00011);
    step(5'b00000);

    // Sole requester is never forced off.
    repeat (20) step(5'b00001);
    step(5'b00000);

    // Random traffic with some persistence so locks last a while.
    r = '0;
    for (int i = 0; i < 400; i++) begin
      r = r ^ NR'($urandom & $urandom);
      if ($urandom_range(0, 15) == 0) r = '0;
      step(r);
    end

    budget = 10;
    while ((exp_q.size() != 0) && (budget > 0)) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending responses, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
